// File: rtl/cossim_pkg.sv
// Shared types and Q-format constants for the cosine_sim streaming front-end.
package cossim_pkg;

  localparam int COSSIM_DATA_W = 32;
  localparam int COSSIM_FRAC   = 15;
  localparam logic [COSSIM_DATA_W-1:0] COSSIM_ONE = 32'd32768;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } cossim_state_e;

endpackage

// File: rtl/cossim_vec_buf.sv
// Element-pair buffer: two W-entry vectors filled by write index, cleared between
// requests, with running all-zero detection per vector.
module cossim_vec_buf
  import cossim_pkg::*;
#(
  parameter int W      = 5,
  parameter int DATA_W = COSSIM_DATA_W,
  parameter int IDX_W  = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_zero_a,
  output logic              o_zero_b,
  output logic [DATA_W-1:0] o_vec_a [W],
  output logic [DATA_W-1:0] o_vec_b [W]
);

  logic [IDX_W-1:0] r_idx;
  logic             r_zero_a;
  logic             r_zero_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        o_vec_a[i] <= '0;
        o_vec_b[i] <= '0;
      end
      r_idx    <= '0;
      r_zero_a <= 1'b1;
      r_zero_b <= 1'b1;
    end else if (i_clr) begin
      for (int i = 0; i < W; i++) begin
        o_vec_a[i] <= '0;
        o_vec_b[i] <= '0;
      end
      r_idx    <= '0;
      r_zero_a <= 1'b1;
      r_zero_b <= 1'b1;
    end else if (i_wr) begin
      for (int i = 0; i < W; i++) begin
        if (r_idx == IDX_W'(i)) begin
          o_vec_a[i] <= i_a;
          o_vec_b[i] <= i_b;
        end
      end
      r_idx    <= r_idx + IDX_W'(1);
      r_zero_a <= r_zero_a & (i_a == '0);
      r_zero_b <= r_zero_b & (i_b == '0);
    end
  end

  // Zero flags include the element being written this cycle, so the closing
  // beat can already decide between bypass and core request.
  assign o_idx    = r_idx;
  assign o_zero_a = r_zero_a & ~(i_wr & (i_a != '0));
  assign o_zero_b = r_zero_b & ~(i_wr & (i_b != '0));

endmodule

// File: rtl/cossim_stream_ctrl.sv
// Initiator for the cosine_sim core: gathers element pairs, issues start, collects
// the result (or a zero/timeout bypass) and offers it on a valid/ready port.
//
// state | meaning
// LOAD  | accepting element pairs until in_last or the W-th element
// START | one-cycle core_start pulse, WAIT counter cleared
// WAIT  | vectors held for the core; leave on core_valid or timeout
// HOLD  | result presented with out_valid until out_ready
module cossim_stream_ctrl
  import cossim_pkg::*;
#(
  parameter int W       = 5,
  parameter int DATA_W  = COSSIM_DATA_W,
  parameter int FRAC    = COSSIM_FRAC,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic                   in_last,
  output logic                   core_start,
  output logic [DATA_W-1:0]      core_vec_a [W],
  output logic [DATA_W-1:0]      core_vec_b [W],
  input  logic [DATA_W-1:0]      core_similarity,
  input  logic                   core_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_similarity,
  output logic [$clog2(W+1)-1:0] out_count,
  output logic                   out_zero,
  output logic                   out_timeout
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (W < 1 || FRAC >= DATA_W) begin : g_bad_params
    $error("cossim_stream_ctrl: need W >= 1 and FRAC < DATA_W");
  end

  cossim_state_e    r_state;
  cossim_state_e    w_state_nxt;
  logic [TMO_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_idx;
  logic             w_zero_a;
  logic             w_zero_b;
  logic             w_wr;
  logic             w_clr;
  logic             w_close;
  logic             w_tmo_hit;

  cossim_vec_buf #(
    .W      (W),
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_vec_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_wr     (w_wr),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_idx    (w_idx),
    .o_zero_a (w_zero_a),
    .o_zero_b (w_zero_b),
    .o_vec_a  (core_vec_a),
    .o_vec_b  (core_vec_b)
  );

  assign w_close   = w_wr && (in_last || (w_idx == CNT_W'(W - 1)));
  assign w_tmo_hit = (r_wait_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_clr       = 1'b0;
    in_ready    = 1'b0;
    core_start  = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = rst_n;
        w_wr     = in_valid;
        if (w_close) w_state_nxt = (w_zero_a || w_zero_b) ? HOLD : START;
      end
      START: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (core_valid || w_tmo_hit) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_clr       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Result fields are settled on the edge that enters HOLD and frozen there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt     <= '0;
      out_similarity <= '0;
      out_count      <= '0;
      out_zero       <= 1'b0;
      out_timeout    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_close) begin
            out_similarity <= '0;
            out_count      <= w_idx + CNT_W'(1);
            out_zero       <= w_zero_a || w_zero_b;
            out_timeout    <= 1'b0;
          end
        end
        START: r_wait_cnt <= '0;
        WAIT: begin
          if (core_valid) begin
            out_similarity <= core_similarity;
          end else if (w_tmo_hit) begin
            out_similarity <= '0;
            out_timeout    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cossim_stream_ctrl.sv
// Bench for cossim_stream_ctrl: directed scenarios with literal expectations, then
// randomized streaming checked every cycle against a queue-based behavioural model.
module tb_cossim_stream_ctrl;
  import cossim_pkg::*;

  localparam int W   = 5;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int CW  = $clog2(W + 1);
  localparam logic [DW-1:0] NEG_ONE = 32'hFFFF8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          core_valid = 1'b0;
  logic [DW-1:0] core_similarity = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          core_start;
  logic [DW-1:0] core_vec_a [W];
  logic [DW-1:0] core_vec_b [W];
  logic          out_valid;
  logic [DW-1:0] out_similarity;
  logic [CW-1:0] out_count;
  logic          out_zero;
  logic          out_timeout;

  cossim_stream_ctrl #(.W(W), .DATA_W(DW), .FRAC(15), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .core_start(core_start),
    .core_vec_a(core_vec_a), .core_vec_b(core_vec_b),
    .core_similarity(core_similarity), .core_valid(core_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_similarity(out_similarity),
    .out_count(out_count), .out_zero(out_zero), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: what has been received, and what the block owes next.
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  bit            m_loading = 1'b1;
  bit            m_start_due = 1'b0;
  bit            m_has_res = 1'b0;
  int            m_age = -1;
  logic [DW-1:0] m_sim = '0;
  int            m_count = 0;
  bit            m_zero = 1'b0;
  bit            m_tmo = 1'b0;

  initial begin
    bit za, zb;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_a.delete(); q_b.delete();
        m_loading = 1'b1; m_start_due = 1'b0; m_has_res = 1'b0; m_age = -1;
      end else if (m_loading) begin
        if (in_valid) begin
          q_a.push_back(in_a);
          q_b.push_back(in_b);
          if (in_last || q_a.size() == W) begin
            za = 1'b1; zb = 1'b1;
            foreach (q_a[i]) begin
              if (q_a[i] != '0) za = 1'b0;
              if (q_b[i] != '0) zb = 1'b0;
            end
            m_loading = 1'b0;
            m_count   = q_a.size();
            if (za || zb) begin
              m_sim = '0; m_zero = 1'b1; m_tmo = 1'b0; m_has_res = 1'b1;
            end else begin
              m_start_due = 1'b1;
            end
          end
        end
      end else if (m_start_due) begin
        m_start_due = 1'b0;
        m_age = 0;
      end else if (m_age >= 0) begin
        if (core_valid) begin
          m_sim = core_similarity; m_zero = 1'b0; m_tmo = 1'b0;
          m_has_res = 1'b1; m_age = -1;
        end else if (m_age == TMO - 1) begin
          m_sim = '0; m_zero = 1'b0; m_tmo = 1'b1;
          m_has_res = 1'b1; m_age = -1;
        end else begin
          m_age++;
        end
      end else if (m_has_res && out_ready) begin
        m_has_res = 1'b0;
        q_a.delete(); q_b.delete();
        m_loading = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic [DW-1:0] ea, eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_similarity", out_similarity, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_timeout", out_timeout, 0);
      end else begin
        chk("in_ready", in_ready, m_loading);
        chk("core_start", core_start, m_start_due);
        chk("out_valid", out_valid, m_has_res);
        if (m_has_res) begin
          chk("out_similarity", out_similarity, m_sim);
          chk("out_count", out_count, m_count);
          chk("out_zero", out_zero, m_zero);
          chk("out_timeout", out_timeout, m_tmo);
        end
        if (m_start_due || m_age >= 0) begin
          for (int i = 0; i < W; i++) begin
            ea = '0; eb = '0;
            if (i < q_a.size()) begin ea = q_a[i]; eb = q_b[i]; end
            chk($sformatf("core_vec_a[%0d]", i), core_vec_a[i], ea);
            chk($sformatf("core_vec_b[%0d]", i), core_vec_b[i], eb);
          end
        end
      end
    end
  end

  // Core stand-in: answers a start after a chosen latency (negative = never).
  int            resp_lat = -1;
  logic [DW-1:0] resp_sim = '0;
  bit            resp_rand = 1'b0;
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        lat = resp_rand ? int'($urandom_range(0, 20)) : resp_lat;
        if (lat >= 0) begin
          repeat (lat) @(posedge clk);
          if (lat > 0) #1;
          core_valid = 1'b1;
          core_similarity = resp_rand ? DW'($urandom) : resp_sim;
          @(posedge clk); #1;
          core_valid = 1'b0;
        end
      end
    end
  end

  bit rand_rdy = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit last,
                      input int gap, output int acc);
    int n;
    repeat (gap) sync();
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin chk("beat_accept_bound", in_ready, 1); break; end
    end
    sync();
    in_valid = 1'b0; in_last = 1'b0; in_a = DW'($urandom); in_b = DW'($urandom);
    acc = cyc;
  endtask

  task automatic wait_valid(input int maxc, input string nm, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (out_valid) begin at = cyc; break; end
    end
    if (at < 0) chk(nm, out_valid, 1);
  endtask

  function automatic logic [DW-1:0] rnd_elem();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return COSSIM_ONE;
      2: return NEG_ONE;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    int t, at, len, mode;
    bit last;
    logic [DW-1:0] a, b;
    logic [DW-1:0] ea [W];
    logic [DW-1:0] eb [W];

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Five full-scale pairs, core answers 32768 after 8 cycles.
    sync();
    resp_lat = 8; resp_sim = COSSIM_ONE; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(COSSIM_ONE, COSSIM_ONE, i == 4, 0, t);
    @(negedge clk); chk("t1_start_high", core_start, 1);
    @(negedge clk); chk("t1_start_one_cycle", core_start, 0);
    wait_valid(40, "t1_out_valid_bound", at);
    chk("t1_result_latency", at - t, 9);
    chk("t1_similarity", out_similarity, 32768);
    chk("t1_count", out_count, 5);
    chk("t1_zero", out_zero, 0);
    chk("t1_timeout", out_timeout, 0);

    // Short orthogonal vectors, zero padded.
    sync();
    resp_lat = 2; resp_sim = '0;
    beat(COSSIM_ONE, '0, 1'b0, 0, t);
    beat('0, COSSIM_ONE, 1'b1, 0, t);
    @(negedge clk);
    chk("t2_start", core_start, 1);
    ea = '{32'd32768, 32'd0, 32'd0, 32'd0, 32'd0};
    eb = '{32'd0, 32'd32768, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < W; i++) begin
      chk($sformatf("t2_vec_a[%0d]", i), core_vec_a[i], ea[i]);
      chk($sformatf("t2_vec_b[%0d]", i), core_vec_b[i], eb[i]);
    end
    wait_valid(40, "t2_out_valid_bound", at);
    chk("t2_similarity", out_similarity, 0);
    chk("t2_count", out_count, 2);

    // Zero vector A bypasses the core.
    sync();
    for (int i = 0; i < 5; i++) beat('0, COSSIM_ONE, i == 4, 0, t);
    @(negedge clk);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_no_start", core_start, 0);
    chk("t3_zero", out_zero, 1);
    chk("t3_similarity", out_similarity, 0);
    chk("t3_count", out_count, 5);

    // Core silent: timeout 16 cycles after WAIT entry, late core_valid ignored.
    sync();
    resp_lat = -1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(COSSIM_ONE, 32'd16384, i == 4, 0, t);
    wait_valid(60, "t4_out_valid_bound", at);
    chk("t4_timeout_latency", at - t, 17);
    chk("t4_timeout", out_timeout, 1);
    chk("t4_similarity", out_similarity, 0);
    sync();
    core_valid = 1'b1; core_similarity = 32'h1234;
    sync();
    core_valid = 1'b0;
    @(negedge clk);
    chk("t4_spurious_sim", out_similarity, 0);
    chk("t4_spurious_tmo", out_timeout, 1);
    chk("t4_still_valid", out_valid, 1);
    out_ready = 1'b1;

    // Negative result held under backpressure.
    sync();
    out_ready = 1'b0; resp_lat = 4; resp_sim = NEG_ONE;
    for (int i = 0; i < 5; i++) beat(COSSIM_ONE, NEG_ONE, i == 4, 0, t);
    wait_valid(40, "t5_out_valid_bound", at);
    for (int k = 0; k < 10; k++) begin
      chk("t5_similarity_hold", out_similarity, 32'hFFFF8000);
      chk("t5_in_ready_low", in_ready, 0);
      chk("t5_valid_hold", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;

    // Reset during WAIT aborts the request.
    sync();
    resp_lat = -1;
    for (int i = 0; i < 5; i++) beat(COSSIM_ONE, COSSIM_ONE, i == 4, 0, t);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_out_similarity", out_similarity, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_vec_a0", core_vec_a[0], 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_after_release", in_ready, 1);
    sync();
    resp_lat = 3; resp_sim = 32'd12345;
    for (int i = 0; i < 5; i++) beat(32'd100 + DW'(i), 32'd7, i == 4, 0, t);
    wait_valid(40, "t6_out_valid_bound", at);
    chk("t6_similarity", out_similarity, 12345);
    chk("t6_count", out_count, 5);

    // Randomized streaming against the model.
    sync();
    resp_rand = 1'b1; rand_rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      len  = $urandom_range(1, W);
      mode = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) begin
        a = rnd_elem(); b = rnd_elem();
        if (mode == 0) a = '0;
        if (mode == 1) b = '0;
        if (i != len - 1) last = 1'b0;
        else if (len < W) last = 1'b1;
        else last = ($urandom_range(0, 1) == 1);
        beat(a, b, last, $urandom_range(0, 2), t);
      end
    end
    rand_rdy = 1'b0;
    sync();
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cossim_stream_ctrl.md
# cossim_stream_ctrl

Streaming front-end and result collector for the `cosine_sim` core; it is the initiator side of the core's start/valid protocol. It accepts element pairs one per handshake, assembles two W-element vectors, and pulses `start` to the core. It then waits for the core's `valid`, captures `similarity`, and presents it on a valid/ready output port. It also handles short vectors, zero vectors and core time-outs, so the core never sees a degenerate request.

## Interface
- `W`, 5: elements per vector; must be ≥ 1.
- `DATA_W`, 32: element and result width; signed fixed point.
- `FRAC`, 15: fractional bits. Q-format is shared with the core; 1.0 = 32768.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT before the request is aborted.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  element pair present.
- `in_ready`  out  1  block can accept an element pair.
- `in_a`  in  DATA_W  element of vector A.
- `in_b`  in  DATA_W  element of vector B.
- `in_last`  in  1  final element of this vector pair.
- `core_start`  out  1  one-cycle start pulse to `cosine_sim`.
- `core_vec_a`  out  DATA_W × W  unpacked array; entry i holds element i.
- `core_vec_b`  out  DATA_W × W  unpacked array; entry i holds element i.
- `core_similarity`  in  DATA_W  core result.
- `core_valid`  in  1  core result valid.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_similarity`  out  DATA_W  signed Q(FRAC) result.
- `out_count`  out  $clog2(W+1)  number of elements received for this result.
- `out_zero`  out  1  vector A or vector B was all-zero; the core was bypassed.
- `out_timeout`  out  1  the core did not respond within TIMEOUT cycles.

## Operation
- States: LOAD, START, WAIT, HOLD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid && in_ready`) writes `in_a` / `in_b` at index `idx`, then increments `idx`.
  - The vector closes on `in_last`, or on the W-th element, whichever comes first.
  - A W-th element without `in_last` is still accepted and closes the vector. No error is flagged.
  - Entries not written stay 0, so short vectors are zero-padded.
  - A zero flag per vector (all elements received so far equal 0) is tracked during loading.
  - On close, go to HOLD with `out_similarity` = 0 and `out_zero` = 1 if either vector is zero. Otherwise go to START.
- **START**
  - `core_start` = 1 for exactly one cycle.
  - Next state is WAIT, and the WAIT counter is cleared.
- **WAIT**
  - `core_vec_a` / `core_vec_b` are held stable from START until WAIT is left.
  - On `core_valid` = 1: capture `core_similarity` and go to HOLD.
  - When the counter reaches TIMEOUT−1 without `core_valid`: go to HOLD with `out_similarity` = 0 and `out_timeout` = 1.
  - A `core_valid` arriving in any state other than WAIT is ignored.
- **HOLD**
  - `out_valid` = 1, and all `out_*` fields are held stable.
  - On `out_ready`: clear both buffers, `idx` and the flags, then go to LOAD.
- The block performs no arithmetic on the data. The result is passed through bit-exact.
- Reset:
  - State goes to LOAD and all buffers and flags clear.
  - `in_ready` = 0 while `rst_n` = 0, and 1 in the first cycle after release.
  - `core_start`, `out_valid`, `out_similarity`, `out_count`, `out_zero` and `out_timeout` all reset to 0.
  - Reset mid-operation aborts the request with no result and no `core_start`.

## Timing
- Last element accepted at edge t: `core_start` is high in cycle t+1.
- Zero vector: `out_valid` is high in cycle t+1.
- `core_valid` sampled at edge c: `out_valid` is high from cycle c+1.
- Timeout: `out_valid` is high TIMEOUT cycles after the WAIT entry edge.
- With `out_ready` held high, HOLD lasts 1 cycle and `in_ready` returns in the next cycle.
- Throughput is one vector pair per W + 2 + core latency + 1 cycles.
- `in_ready` = 0 in START, WAIT and HOLD. There is no input skid buffering.
- `in_valid` with `in_last` on the first beat gives a vector of length 1, with `out_count` = 1.

## Structure
- Package `cossim_pkg`:
  - state enum `cossim_state_e` (LOAD, START, WAIT, HOLD);
  - `COSSIM_DATA_W` = 32, `COSSIM_FRAC` = 15;
  - Q-format constant `COSSIM_ONE` = 32768.
- Sub-module `cossim_vec_buf`:
  - two W-entry register arrays with write index, synchronous clear and zero detect;
  - it drives `core_vec_a` and `core_vec_b`.
- The top level holds the FSM, the WAIT counter and the output registers.

## Test plan
- Five pairs of (32768, 32768), the last with `in_last`, core model returning 32768 after 8 cycles: `core_start` is one cycle long one cycle after the last beat; then `out_valid` with `out_similarity` = 32768, `out_count` = 5, and `out_zero` = `out_timeout` = 0.
- A = (32768, 0), B = (0, 32768), `in_last` on beat 2, core returns 0: core sees `vec_a` = {32768, 0, 0, 0, 0} and `vec_b` = {0, 32768, 0, 0, 0}; output is 0 with `out_count` = 2.
- A all zero, B = 32768 × 5: `core_start` is never asserted; next cycle `out_valid` with similarity 0 and `out_zero` = 1.
- Core never asserts `core_valid`, TIMEOUT = 16: exactly 16 cycles after WAIT entry, `out_valid` with `out_timeout` = 1 and similarity 0. A later spurious `core_valid` changes nothing.
- A = 32768 × 5, B = −32768 × 5 (0xFFFF8000) with `out_ready` held low for 10 cycles: output is 0xFFFF8000, stable for all 10 cycles; `in_ready` = 0 throughout.
- Assert `rst_n` low during WAIT: all outputs read 0. After release, `in_ready` = 1 and a fresh vector completes normally.
